// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared encodings for the multiply/divide scheduler:
//                md_op codes, the IDLE/RUN state encoding and the counter
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module      : md_arith
//  Description : Combinational multiply/divide datapath. Produces the HI/LO
//                pair for MULT/MULTU (64-bit product) and DIV/DIVU
//                (remainder/quotient), including the divide-by-zero and
//                signed-overflow results. Other op codes yield zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_arith
   import md_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_div_zero;
   logic        w_div_ovf;

   // Sign- or zero-extend to 64 bits so the low 64 product bits are exact.
   assign w_prod_s   = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign w_prod_u   = {32'd0, a_i} * {32'd0, b_i};
   assign w_div_zero = (b_i == 32'd0);
   // Most-negative / -1 does not fit in 32 bits; pin the result explicitly.
   assign w_div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

   // Select the HI/LO pair for the requested operation.
   always_comb begin
      hi_o = 32'd0;
      lo_o = 32'd0;
      case (op_i)
         OP_MULT:  {hi_o, lo_o} = w_prod_s;
         OP_MULTU: {hi_o, lo_o} = w_prod_u;
         OP_DIV: begin
            if (w_div_zero) begin
               lo_o = 32'hFFFF_FFFF;
               hi_o = a_i;
            end else if (w_div_ovf) begin
               lo_o = 32'h8000_0000;
               hi_o = 32'd0;
            end else begin
               lo_o = $signed(a_i) / $signed(b_i);
               hi_o = $signed(a_i) % $signed(b_i);
            end
         end
         OP_DIVU: begin
            if (w_div_zero) begin
               lo_o = 32'hFFFF_FFFF;
               hi_o = a_i;
            end else begin
               lo_o = a_i / b_i;
               hi_o = a_i % b_i;
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/md_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : md_scheduler
//  Description : E-stage multiply/divide sequencer. Accepts one md op per
//                start, holds the result for MULT_LAT/DIV_LAT busy cycles and
//                then commits HI/LO. A CP0 request cancels the E-stage op.
//                Optional feature macro MD_PERF_EN adds busy-cycle and
//                operation counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_scheduler
   import md_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op,
   input  logic        md_valid,
   input  logic        m_req,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] hl_data,
   output logic        md_busy,
   output logic [31:0] hi,
   output logic [31:0] lo
`ifdef MD_PERF_EN
   ,
   output logic [31:0] perf_busy_cycles,
   output logic [15:0] perf_ops
`endif
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d;
   logic [31:0]      pend_lo_q, pend_lo_d;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_is_div;
   logic             w_start;
   logic [CNT_W-1:0] w_lat_m1;
   logic [31:0]      w_res_hi;
   logic [31:0]      w_res_lo;

   md_arith u_arith (
      .op_i (md_op),
      .a_i  (rs_data),
      .b_i  (rt_data),
      .hi_o (w_res_hi),
      .lo_o (w_res_lo)
   );

   assign w_accept = md_valid && !m_req && (state_q == ST_IDLE);
   assign w_is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
   assign w_is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
   assign w_start  = w_accept && (w_is_mul || w_is_div);
   assign w_lat_m1 = w_is_mul ? CNT_W'(MULT_LAT - 1) : CNT_W'(DIV_LAT - 1);

   assign md_busy  = (state_q == ST_RUN) || w_start;
   assign hi       = hi_q;
   assign lo       = lo_q;

   // Move-from reads only ever see committed HI/LO.
   always_comb begin
      hl_data = 32'd0;
      if (md_op == OP_MFHI)      hl_data = hi_q;
      else if (md_op == OP_MFLO) hl_data = lo_q;
   end

   // Next-state logic. The start cycle is itself the first busy cycle, so
   // RUN lasts LAT-1 cycles: cnt holds LAT-1 on entry and the result commits
   // on the edge where cnt steps from 1 to 0. LAT==1 commits at the start edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      case (state_q)
         ST_IDLE: begin
            if (w_start) begin
               if (w_lat_m1 == '0) begin
                  hi_d = w_res_hi;
                  lo_d = w_res_lo;
               end else begin
                  pend_hi_d = w_res_hi;
                  pend_lo_d = w_res_lo;
                  cnt_d     = w_lat_m1;
                  state_d   = ST_RUN;
               end
            end else if (w_accept && (md_op == OP_MTHI)) begin
               hi_d = rs_data;
            end else if (w_accept && (md_op == OP_MTLO)) begin
               lo_d = rs_data;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM, counter and HI/LO state; reset discards any in-flight result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

`ifdef MD_PERF_EN
   logic [31:0] perf_busy_q;
   logic [15:0] perf_ops_q;

   // Busy cycles wrap naturally; the op counter sticks at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_busy_q <= 32'd0;
         perf_ops_q  <= 16'd0;
      end else begin
         if (md_busy) perf_busy_q <= perf_busy_q + 32'd1;
         if (w_start && (perf_ops_q != 16'hFFFF)) perf_ops_q <= perf_ops_q + 16'd1;
      end
   end

   assign perf_busy_cycles = perf_busy_q;
   assign perf_ops         = perf_ops_q;
`endif

endmodule
`default_nettype wire
